id_fwd_decode_stage: RTL

Parametrised successor of the current decode stage for the MIPS pipeline. It owns the IF/ID pipeline register and holds the instruction fetched during a stall, so the synchronous inst SRAM output is not lost. It resolves operands through NUM_FWD prioritised forwarding sources, raises load-use stall requests per stage mask, and resolves branches and jumps in ID. The regfile sits outside the block; its read ports are driven from here.

---
 rtl/id_fwd_decode_stage.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/id_fwd_decode_stage.sv
// Purpose: MIPS decode stage: owns the IF/ID register, hold buffer, operand forwarding, load-use interlock and branch resolution.
// Latency: IF/ID register is one cycle; operands, stallreq and the branch redirect are combinational from it.
// Backpressure: stall_id freezes the IF/ID register and parks the SRAM word; bubble_id overrides stall_id and inserts an empty slot.
module id_fwd_decode_stage #(
   parameter int                 NUM_FWD   = 3,
   parameter logic [NUM_FWD-1:0] LOAD_MASK = NUM_FWD'(1),
   parameter int                 HOLD_INST = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall_id,
   input  logic                   bubble_id,
   input  logic                   if_valid,
   input  logic [31:0]            if_pc,
   input  logic [31:0]            inst_sram_rdata,
   input  logic [NUM_FWD-1:0]     fwd_we,
   input  logic [5*NUM_FWD-1:0]   fwd_waddr,
   input  logic [32*NUM_FWD-1:0]  fwd_wdata,
   input  logic [NUM_FWD-1:0]     fwd_is_load,
   output logic [4:0]             rf_raddr1,
   output logic [4:0]             rf_raddr2,
   input  logic [31:0]            rf_rdata1,
   input  logic [31:0]            rf_rdata2,
   output logic                   stallreq,
   output logic                   id_valid,
   output logic [31:0]            id_pc,
   output logic [31:0]            id_inst,
   output logic [31:0]            src1_data,
   output logic [31:0]            src2_data,
   output logic                   br_taken,
   output logic [31:0]            br_target
);

   logic        valid;
   logic [31:0] pc;
   logic        hold_v;
   logic [31:0] hold_inst;
   logic [31:0] eff_inst;

   // IF/ID register: reset, then bubble, then stall-hold, else load from IF
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         pc    <= 32'd0;
      end else if (bubble_id) begin
         valid <= 1'b0;
         pc    <= 32'd0;
      end else if (!stall_id) begin
         valid <= if_valid;
         pc    <= if_pc;
      end
   end

   generate
      if (HOLD_INST != 0) begin : g_hold
         // Park the SRAM word on the first stalled cycle; it would otherwise be replaced next cycle
         always_ff @(posedge clk) begin
            if (rst || bubble_id || !stall_id) begin
               hold_v <= 1'b0;
            end else if (!hold_v) begin
               hold_v    <= 1'b1;
               hold_inst <= inst_sram_rdata;
            end
         end
      end else begin : g_no_hold
         assign hold_v    = 1'b0;
         assign hold_inst = 32'd0;
      end
   endgenerate

   assign eff_inst = !valid ? 32'd0 : (hold_v ? hold_inst : inst_sram_rdata);
   assign id_inst  = eff_inst;
   assign id_valid = valid;
   assign id_pc    = pc;

   // Instruction fields
   logic [5:0]  op;
   logic [4:0]  rs, rt;
   logic [15:0] imm;
   logic [5:0]  func;
   logic [25:0] index;
   assign op    = eff_inst[31:26];
   assign rs    = eff_inst[25:21];
   assign rt    = eff_inst[20:16];
   assign imm   = eff_inst[15:0];
   assign func  = eff_inst[5:0];
   assign index = eff_inst[25:0];

   assign rf_raddr1 = rs;
   assign rf_raddr2 = rt;

   // J, JAL and LUI carry non-register bits in the rs field
   logic rs_used, rt_used;
   assign rs_used = !(op == 6'h02 || op == 6'h03 || op == 6'h0F);
   assign rt_used = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op[5:3] == 3'b101);

   // Lowest-index (youngest) matching source wins; result is {load_pending, data}
   function automatic logic [32:0] fwd_resolve(
      input logic [4:0]            r,
      input logic [31:0]           rf,
      input logic [NUM_FWD-1:0]    we,
      input logic [5*NUM_FWD-1:0]  wa,
      input logic [32*NUM_FWD-1:0] wd,
      input logic [NUM_FWD-1:0]    ld
   );
      logic [31:0] d;
      logic        l;
      d = rf;
      l = 1'b0;
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (we[i] && (wa[5*i +: 5] == r)) begin
            d = wd[32*i +: 32];
            l = LOAD_MASK[i] && ld[i];
         end
      end
      if (r == 5'd0) begin
         d = 32'd0;
         l = 1'b0;
      end
      return {l, d};
   endfunction

   logic ld1, ld2;
   assign {ld1, src1_data} = fwd_resolve(rs, rf_rdata1, fwd_we, fwd_waddr, fwd_wdata, fwd_is_load);
   assign {ld2, src2_data} = fwd_resolve(rt, rf_rdata2, fwd_we, fwd_waddr, fwd_wdata, fwd_is_load);

   assign stallreq = valid && ((rs_used && ld1) || (rt_used && ld2));

   logic [31:0] pc_plus4, br_off;
   assign pc_plus4 = pc + 32'd4;
   assign br_off   = {{14{imm[15]}}, imm, 2'b00};

   logic        take;
   logic [31:0] tgt;

   // Branch/jump condition and target, before the valid/stall gate
   always_comb begin
      take = 1'b0;
      tgt  = pc_plus4 + br_off;
      case (op)
         6'h00: begin
            take = (func == 6'h08) || (func == 6'h09);
            tgt  = src1_data;
         end
         6'h01: begin
            if (rt == 5'd0)      take = src1_data[31];
            else if (rt == 5'd1) take = !src1_data[31];
         end
         6'h02, 6'h03: begin
            take = 1'b1;
            tgt  = {pc_plus4[31:28], index, 2'b00};
         end
         6'h04: take = (src1_data == src2_data);
         6'h05: take = (src1_data != src2_data);
         6'h06: take = src1_data[31] || (src1_data == 32'd0);
         6'h07: take = !src1_data[31] && (src1_data != 32'd0);
         default: take = 1'b0;
      endcase
   end

   assign br_taken  = valid && !stallreq && take;
   assign br_target = br_taken ? tgt : 32'd0;

endmodule
